// File: rtl/pokemon_soc_mem_pkg.sv
// Shared types and defaults for the two-requester on-chip memory arbiter.
// The round-robin pick function lives here so the arbiter core stays tiny.
package pokemon_soc_mem_pkg;

    localparam int DEFAULT_ADDR_W = 2;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    // On a tie the requester that was not granted last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        logic pick;
        if (req == 2'b11) begin
            pick = ~last_grant;
        end else begin
            pick = req[1] & ~req[0];
        end
        return pick;
    endfunction

endpackage

// File: rtl/pokemon_soc_rr_arb2.sv
// Two-way round-robin picker with its last-grant pointer.
// The pointer resets to 1 so requester 0 wins the first tie.
module pokemon_soc_rr_arb2
    import pokemon_soc_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       grant
);

    logic last_grant;

    assign grant = rr_pick(req, last_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (take) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/pokemon_soc_onchip_mem_arbiter.sv
// Arbitrates two Avalon-style requesters onto one single-port synchronous memory.
//   state     | meaning
//   ST_IDLE   | waiting for a request; grant and command are captured on exit
//   ST_ACCESS | memory strobed with the owner's command; owner is accepted
//   ST_RESP   | read data arrives from memory and is captured for the owner
module pokemon_soc_onchip_mem_arbiter
    import pokemon_soc_mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                freeze,

    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic                m0_readdatavalid,
    output logic [DATA_W-1:0]   m0_readdata,

    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic                m1_readdatavalid,
    output logic [DATA_W-1:0]   m1_readdata,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,

    output logic                proto_err
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          state;
    arb_state_t          state_next;

    logic [1:0]          req;
    logic                grant;
    logic                grant_take;
    logic                owner;
    logic                owner_req;
    logic                accept;

    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_address;
    logic [BE_W-1:0]     cmd_byteenable;
    logic [DATA_W-1:0]   cmd_writedata;

    logic [DATA_W-1:0]   hold_readdata;
    logic                rdv0;
    logic                rdv1;
    logic                err_flag;

    assign req       = {m1_read | m1_write, m0_read | m0_write};
    assign owner_req = owner ? req[1] : req[0];

    pokemon_soc_rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .take  (grant_take),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request withdrawn before acceptance is dropped without touching memory.
    always_comb begin
        state_next = state;
        grant_take = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!freeze && (req != 2'b00)) begin
                    grant_take = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (owner_req) begin
                    accept     = 1'b1;
                    state_next = cmd_write ? ST_IDLE : ST_RESP;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read+write together is registered as a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner          <= 1'b0;
            cmd_write      <= 1'b0;
            cmd_address    <= '0;
            cmd_byteenable <= '0;
            cmd_writedata  <= '0;
        end else if (grant_take) begin
            owner <= grant;
            if (grant) begin
                cmd_write      <= m1_write;
                cmd_address    <= m1_address;
                cmd_byteenable <= m1_byteenable;
                cmd_writedata  <= m1_writedata;
            end else begin
                cmd_write      <= m0_write;
                cmd_address    <= m0_address;
                cmd_byteenable <= m0_byteenable;
                cmd_writedata  <= m0_writedata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_readdata <= '0;
            rdv0          <= 1'b0;
            rdv1          <= 1'b0;
        end else begin
            rdv0 <= (state == ST_RESP) && !owner;
            rdv1 <= (state == ST_RESP) && owner;
            if (state == ST_RESP) begin
                hold_readdata <= mem_readdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag <= 1'b0;
        end else if ((m0_read && m0_write) || (m1_read && m1_write)) begin
            err_flag <= 1'b1;
        end
    end

    assign m0_waitrequest   = req[0] && !(accept && !owner);
    assign m1_waitrequest   = req[1] && !(accept && owner);
    assign m0_readdatavalid = rdv0;
    assign m1_readdatavalid = rdv1;
    assign m0_readdata      = hold_readdata;
    assign m1_readdata      = hold_readdata;

    assign mem_address    = cmd_address;
    assign mem_byteenable = cmd_byteenable;
    assign mem_writedata  = cmd_writedata;
    assign mem_chipselect = accept;
    assign mem_write      = accept && cmd_write;
    assign mem_clken      = 1'b1;

    assign proto_err = err_flag;

endmodule

// File: tb/tb_pokemon_soc_onchip_mem_arbiter.sv
// Directed bench for the two-requester memory arbiter with a byte-enabled
// synchronous memory model behind it.
module tb_pokemon_soc_onchip_mem_arbiter;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              freeze = 1'b0;
    logic              m0_read = 1'b0, m0_write = 1'b0;
    logic [ADDR_W-1:0] m0_address = '0;
    logic [BE_W-1:0]   m0_byteenable = '0;
    logic [DATA_W-1:0] m0_writedata = '0;
    logic              m0_waitrequest, m0_readdatavalid;
    logic [DATA_W-1:0] m0_readdata;
    logic              m1_read = 1'b0, m1_write = 1'b0;
    logic [ADDR_W-1:0] m1_address = '0;
    logic [BE_W-1:0]   m1_byteenable = '0;
    logic [DATA_W-1:0] m1_writedata = '0;
    logic              m1_waitrequest, m1_readdatavalid;
    logic [DATA_W-1:0] m1_readdata;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              proto_err;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_wdata;
    logic [BE_W-1:0]   last_be;

    always #5 clk = ~clk;

    pokemon_soc_onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .freeze           (freeze),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdatavalid (m0_readdatavalid),
        .m0_readdata      (m0_readdata),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdatavalid (m1_readdatavalid),
        .m1_readdata      (m1_readdata),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .proto_err        (proto_err)
    );

    // Synchronous memory: read data appears the cycle after the address.
    logic [DATA_W-1:0] mem_model [4];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (mem_byteenable[b]) mem_model[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end
            mem_readdata <= mem_model[mem_address];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int m, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    function automatic logic wait_of(input int m);
        return (m == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    // lat counts request cycles including the accept cycle; wp counts mem_write pulses.
    task automatic master_write(input int m, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input logic [BE_W-1:0] be, input logic rd_too,
                                output int lat, output int wp);
        lat = -1;
        wp  = 0;
        set_cmd(m, rd_too, 1'b1, a, be, d);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (mem_write) wp++;
            if (!wait_of(m)) begin
                lat        = c + 1;
                last_addr  = mem_address;
                last_wdata = mem_writedata;
                last_be    = mem_byteenable;
                tick();
                set_cmd(m, 1'b0, 1'b0, '0, '0, '0);
                #1;
                if (mem_write) wp++;
                break;
            end
            tick();
        end
        set_cmd(m, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic master_read(input int m, input logic [ADDR_W-1:0] a, output int acc, output int vcyc,
                               output logic [DATA_W-1:0] data, output int other);
        acc   = -1;
        vcyc  = -1;
        other = 0;
        data  = '0;
        set_cmd(m, 1'b1, 1'b0, a, '1, '0);
        for (int c = 0; c < 20; c++) begin
            #1;
            if ((m == 0) ? m1_readdatavalid : m0_readdatavalid) other++;
            if (vcyc < 0 && ((m == 0) ? m0_readdatavalid : m1_readdatavalid)) begin
                vcyc = c;
                data = (m == 0) ? m0_readdata : m1_readdata;
            end
            if (acc < 0 && !wait_of(m)) acc = c;
            tick();
            if (acc >= 0) set_cmd(m, 1'b0, 1'b0, '0, '0, '0);
            if (vcyc >= 0) break;
        end
        set_cmd(m, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Both requesters read at once (m0 from word 2, m1 from word 1) and hold until accepted.
    task automatic run_pair(output int a0, output int a1, output int r0, output int r1,
                            output logic [DATA_W-1:0] d0, output logic [DATA_W-1:0] d1);
        a0 = -1; a1 = -1; r0 = -1; r1 = -1; d0 = '0; d1 = '0;
        set_cmd(0, 1'b1, 1'b0, 2'd2, '1, '0);
        set_cmd(1, 1'b1, 1'b0, 2'd1, '1, '0);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (a0 < 0 && m0_read && !m0_waitrequest) a0 = c;
            if (a1 < 0 && m1_read && !m1_waitrequest) a1 = c;
            if (r0 < 0 && m0_readdatavalid) begin r0 = c; d0 = m0_readdata; end
            if (r1 < 0 && m1_readdatavalid) begin r1 = c; d1 = m1_readdata; end
            tick();
            if (a0 >= 0) m0_read = 1'b0;
            if (a1 >= 0) m1_read = 1'b0;
            if (r0 >= 0 && r1 >= 0) break;
        end
        m0_read = 1'b0;
        m1_read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_read = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitrequest: got %b expected 1", m0_waitrequest); end
        checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_chipselect: got %b expected 0", mem_chipselect); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
        checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL reset_clken: got %b expected 1", mem_clken); end
        checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv: got %b%b expected 00", m1_readdatavalid, m0_readdatavalid); end
        checks++; if (m0_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 00000000", m0_readdata); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
        m0_read = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int lat, wp;
        master_write(0, 2'd2, 32'hDEADBEEF, 4'hF, 1'b0, lat, wp);
        checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency: got %0d expected 2", lat); end
        checks++; if (wp !== 1) begin errors++; $display("FAIL write_pulses: got %0d expected 1", wp); end
        checks++; if (last_addr !== 2'd2) begin errors++; $display("FAIL write_address: got %0d expected 2", last_addr); end
        checks++; if (last_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data: got %h expected deadbeef", last_wdata); end
        checks++; if (last_be !== 4'hF) begin errors++; $display("FAIL write_be: got %h expected f", last_be); end
    endtask

    task automatic test_read();
        int acc, vcyc, other;
        logic [DATA_W-1:0] data;
        master_read(0, 2'd2, acc, vcyc, data, other);
        checks++; if (acc !== 1) begin errors++; $display("FAIL read_accept: got %0d expected 1", acc); end
        checks++; if (vcyc !== 3) begin errors++; $display("FAIL read_valid_cycle: got %0d expected 3", vcyc); end
        checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", data); end
        checks++; if (other !== 0) begin errors++; $display("FAIL read_other_rdv: got %0d expected 0", other); end
    endtask

    task automatic test_byteenable();
        int lat, wp, acc, vcyc, other;
        logic [DATA_W-1:0] data;
        master_write(1, 2'd1, 32'hAAAAAAAA, 4'hF, 1'b0, lat, wp);
        master_write(1, 2'd1, 32'h00001234, 4'h3, 1'b0, lat, wp);
        checks++; if (last_be !== 4'h3) begin errors++; $display("FAIL be_partial_be: got %h expected 3", last_be); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL be_m1_latency: got %0d expected 2", lat); end
        master_read(0, 2'd1, acc, vcyc, data, other);
        checks++; if (data !== 32'hAAAA1234) begin errors++; $display("FAIL be_merge_data: got %h expected aaaa1234", data); end
    endtask

    task automatic test_tie();
        int a0, a1, r0, r1;
        logic [DATA_W-1:0] d0, d1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        run_pair(a0, a1, r0, r1, d0, d1);
        checks++; if (a0 !== 1 || a1 !== 4) begin errors++; $display("FAIL tie_order: got m0@%0d m1@%0d expected m0@1 m1@4", a0, a1); end
        checks++; if (r0 !== 3 || r1 !== 6) begin errors++; $display("FAIL tie_valid: got m0@%0d m1@%0d expected m0@3 m1@6", r0, r1); end
        checks++; if (d0 !== 32'hDEADBEEF) begin errors++; $display("FAIL tie_m0_data: got %h expected deadbeef", d0); end
        checks++; if (d1 !== 32'hAAAA1234) begin errors++; $display("FAIL tie_m1_data: got %h expected aaaa1234", d1); end
        run_pair(a0, a1, r0, r1, d0, d1);
        checks++; if (a0 !== 1 || a1 !== 4) begin errors++; $display("FAIL tie_again_order: got m0@%0d m1@%0d expected m0@1 m1@4", a0, a1); end
    endtask

    task automatic test_round_robin();
        int a0, a1, r0, r1, acc, vcyc, other;
        logic [DATA_W-1:0] d0, d1, data;
        master_read(0, 2'd2, acc, vcyc, data, other);
        run_pair(a0, a1, r0, r1, d0, d1);
        checks++; if (a1 !== 1 || a0 !== 4) begin errors++; $display("FAIL rr_order: got m0@%0d m1@%0d expected m1@1 m0@4", a0, a1); end
        checks++; if (r1 !== 3 || r0 !== 6) begin errors++; $display("FAIL rr_valid: got m0@%0d m1@%0d expected m1@3 m0@6", r0, r1); end
    endtask

    task automatic test_freeze();
        int a0 = -1, a1 = -1, r0 = -1, r1 = -1;
        logic [DATA_W-1:0] d0 = '0;
        set_cmd(0, 1'b1, 1'b0, 2'd2, '1, '0);
        for (int c = 0; c < 30; c++) begin
            if (c == 8) freeze = 1'b0;
            #1;
            if (a0 < 0 && m0_read && !m0_waitrequest) a0 = c;
            if (a1 < 0 && m1_read && !m1_waitrequest) a1 = c;
            if (r0 < 0 && m0_readdatavalid) begin r0 = c; d0 = m0_readdata; end
            if (r1 < 0 && m1_readdatavalid) r1 = c;
            if (c == 1) begin
                freeze = 1'b1;
                set_cmd(1, 1'b1, 1'b0, 2'd1, '1, '0);
            end
            tick();
            if (a0 >= 0) m0_read = 1'b0;
            if (a1 >= 0) m1_read = 1'b0;
            if (r1 >= 0) break;
        end
        freeze = 1'b0;
        m0_read = 1'b0;
        m1_read = 1'b0;
        checks++; if (a0 !== 1) begin errors++; $display("FAIL freeze_m0_accept: got %0d expected 1", a0); end
        checks++; if (r0 !== 3) begin errors++; $display("FAIL freeze_m0_valid: got %0d expected 3", r0); end
        checks++; if (d0 !== 32'hDEADBEEF) begin errors++; $display("FAIL freeze_m0_data: got %h expected deadbeef", d0); end
        checks++; if (a1 !== 9) begin errors++; $display("FAIL freeze_m1_accept: got %0d expected 9", a1); end
        checks++; if (r1 !== 11) begin errors++; $display("FAIL freeze_m1_valid: got %0d expected 11", r1); end
    endtask

    task automatic test_proto_err();
        int lat, wp, acc, vcyc, other;
        logic [DATA_W-1:0] data;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_before: got %b expected 0", proto_err); end
        master_write(0, 2'd3, 32'h12345678, 4'hF, 1'b1, lat, wp);
        checks++; if (wp !== 1) begin errors++; $display("FAIL proto_write_pulses: got %0d expected 1", wp); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set: got %b expected 1", proto_err); end
        master_read(0, 2'd3, acc, vcyc, data, other);
        checks++; if (data !== 32'h12345678) begin errors++; $display("FAIL proto_written_data: got %h expected 12345678", data); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
    endtask

    task automatic test_reset_mid_read();
        int rdv_seen = 0;
        int acc, vcyc, other;
        logic [DATA_W-1:0] data;
        set_cmd(0, 1'b1, 1'b0, 2'd3, '1, '0);
        tick();
        tick();
        set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        reset = 1'b1;
        #1;
        checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL midreset_chipselect: got %b expected 0", mem_chipselect); end
        for (int c = 0; c < 5; c++) begin
            if (m0_readdatavalid || m1_readdatavalid) rdv_seen++;
            tick();
            if (c == 1) reset = 1'b0;
            #1;
        end
        checks++; if (rdv_seen !== 0) begin errors++; $display("FAIL midreset_rdv: got %0d expected 0", rdv_seen); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL midreset_proto_err: got %b expected 0", proto_err); end
        master_read(0, 2'd3, acc, vcyc, data, other);
        checks++; if (acc !== 1 || vcyc !== 3) begin errors++; $display("FAIL midreset_idle: got accept %0d valid %0d expected 1 and 3", acc, vcyc); end
        checks++; if (data !== 32'h12345678) begin errors++; $display("FAIL midreset_data: got %h expected 12345678", data); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_byteenable();
        test_tie();
        test_round_robin();
        test_freeze();
        test_proto_err();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
